del_meas_engine: RTL and testbench

- Parametrised multi-channel successor to the single-shot delay measurement in the experiment FSM.
- Fires a pulse on a selectable subset of DAC channels, then times every ADC channel until its magnitude crosses a threshold.
- Repeats for a programmable number of trials with a zero-output settle gap between them, and reports per-channel summed latency plus timeout flags.
- Sits between the CPU control registers and the DAC/ADC driver buses, muxed with the experiment sequencer.

---
 rtl/del_meas_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_del_meas_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/del_meas_engine.sv
// -----------------------------------------------------------------------------
// del_meas_engine
//
// Multi-channel delay measurement engine. A run fires one pulse on the DAC
// channels selected by dac_sel, then counts cycles until each ADC channel's
// magnitude rises strictly above thresh. The fire/measure sequence repeats
// for num_reps+1 trials, with SETTLE_CYCLES zero-output cycles between trials.
// Per-channel latencies are summed, saturating, into result. A channel that
// is never detected within TIMEOUT cycles raises tmo_flags and pins its result
// at all ones for the rest of the run.
//
// Optional build macro: DEL_MEAS_MINMAX_EN adds lat_min / lat_max outputs that
// hold the per-channel minimum / maximum latency over non-timed-out trials.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       level trigger; a rising edge seen in IDLE starts a run
//   dac_sel     mask of DAC channels that carry the pulse
//   pulse_val   pulse amplitude
//   thresh      detection threshold (unsigned magnitude)
//   num_reps    number of trials minus one
//   dac_out     DAC samples, channel k at [k*NUM_BITS +: NUM_BITS]
//   dac_valid   per-DAC valid
//   adc_in      ADC samples, same packing as dac_out
//   adc_valid   per-ADC valid
//   adc_run     enables the ADC drivers while measuring
//   result      per-channel summed latency, channel i at [i*CNT_W +: CNT_W]
//   tmo_flags   per-channel timeout seen during the run
//   busy        run in progress
//   done        results valid (held until the next start edge)
//   lat_min/lat_max (DEL_MEAS_MINMAX_EN only) per-channel latency extremes
// -----------------------------------------------------------------------------
module del_meas_engine #(
    parameter int NUM_BITS      = 16,
    parameter int NUM_DAC       = 3,
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT       = 255,
    parameter int REP_W         = 4,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_DAC-1:0]          dac_sel,
    input  logic [NUM_BITS-1:0]         pulse_val,
    input  logic [NUM_BITS-1:0]         thresh,
    input  logic [REP_W-1:0]            num_reps,
    output logic [NUM_DAC*NUM_BITS-1:0] dac_out,
    output logic [NUM_DAC-1:0]          dac_valid,
    input  logic [NUM_CH*NUM_BITS-1:0]  adc_in,
    input  logic [NUM_CH-1:0]           adc_valid,
    output logic                        adc_run,
    output logic [NUM_CH*CNT_W-1:0]     result,
    output logic [NUM_CH-1:0]           tmo_flags,
    output logic                        busy,
`ifdef DEL_MEAS_MINMAX_EN
    output logic [NUM_CH*CNT_W-1:0]     lat_min,
    output logic [NUM_CH*CNT_W-1:0]     lat_max,
`endif
    output logic                        done
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]            CNT_ONES  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]            CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [NUM_DAC-1:0]          DAC_ALL   = {NUM_DAC{1'b1}};
    localparam logic [NUM_DAC*NUM_BITS-1:0] DAC_ZERO  = {(NUM_DAC*NUM_BITS){1'b0}};
    localparam logic [NUM_CH*CNT_W-1:0]     RES_ZERO  = {(NUM_CH*CNT_W){1'b0}};
    localparam logic [NUM_CH*CNT_W-1:0]     RES_ONES  = {(NUM_CH*CNT_W){1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRE   = 3'd1,
        ST_MEAS   = 3'd2,
        ST_ACC    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                         state_r;
    logic                           start_prev_r;
    logic [CNT_W-1:0]               cnt_r;
    logic [NUM_CH-1:0]              det_r;
    logic [NUM_CH-1:0][CNT_W-1:0]   lat_r;
    logic [REP_W-1:0]               trial_r;
    logic [SET_W-1:0]               settle_r;

    logic [NUM_DAC*NUM_BITS-1:0]    fire_data_s;
    logic [NUM_CH-1:0]              hit_s;
    logic [NUM_CH-1:0]              det_next_s;

    // Two's-complement magnitude; the most-negative code has no positive
    // counterpart and saturates to the largest positive value.
    function automatic logic [NUM_BITS-1:0] abs_sat(input logic [NUM_BITS-1:0] x);
        logic [NUM_BITS-1:0] neg_min;
        neg_min = {1'b1, {(NUM_BITS-1){1'b0}}};
        if (x == neg_min) begin
            abs_sat = {1'b0, {(NUM_BITS-1){1'b1}}};
        end else if (x[NUM_BITS-1]) begin
            abs_sat = (~x) + NUM_BITS'(1'b1);
        end else begin
            abs_sat = x;
        end
    endfunction

    // Unsigned add that clamps to all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            sat_add = CNT_ONES;
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Pulse pattern for the fire cycle and per-channel threshold crossings.
    always_comb begin
        fire_data_s = DAC_ZERO;
        hit_s       = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_DAC; k++) begin
            if (dac_sel[k]) begin
                fire_data_s[k*NUM_BITS +: NUM_BITS] = pulse_val;
            end else begin
                fire_data_s[k*NUM_BITS +: NUM_BITS] = {NUM_BITS{1'b0}};
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            hit_s[i] = adc_valid[i] && !det_r[i] &&
                       (abs_sat(adc_in[i*NUM_BITS +: NUM_BITS]) > thresh);
        end
        det_next_s = det_r | hit_s;
    end

    // Sequencer with registered outputs; outputs are loaded on the edge that
    // enters each state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            start_prev_r <= 1'b0;
            cnt_r        <= CNT_ZERO;
            det_r        <= {NUM_CH{1'b0}};
            lat_r        <= RES_ZERO;
            trial_r      <= {REP_W{1'b0}};
            settle_r     <= {SET_W{1'b0}};
            dac_out      <= DAC_ZERO;
            dac_valid    <= {NUM_DAC{1'b0}};
            adc_run      <= 1'b0;
            result       <= RES_ZERO;
            tmo_flags    <= {NUM_CH{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef DEL_MEAS_MINMAX_EN
            lat_min      <= RES_ONES;
            lat_max      <= RES_ZERO;
`endif
        end else begin
            start_prev_r <= start;
            case (state_r)
                ST_IDLE: begin
                    if (start && !start_prev_r) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        result    <= RES_ZERO;
                        tmo_flags <= {NUM_CH{1'b0}};
                        trial_r   <= {REP_W{1'b0}};
                        dac_out   <= fire_data_s;
                        dac_valid <= DAC_ALL;
                        adc_run   <= 1'b1;
`ifdef DEL_MEAS_MINMAX_EN
                        lat_min   <= RES_ONES;
                        lat_max   <= RES_ZERO;
`endif
                        state_r   <= ST_FIRE;
                    end
                end

                ST_FIRE: begin
                    // The first measurement cycle reports a latency of 1.
                    cnt_r   <= CNT_W'(1'b1);
                    det_r   <= {NUM_CH{1'b0}};
                    dac_out <= DAC_ZERO;
                    state_r <= ST_MEAS;
                end

                ST_MEAS: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (hit_s[i]) begin
                            lat_r[i] <= cnt_r;
                        end
                    end
                    det_r <= det_next_s;
                    // Detection on the TIMEOUT cycle is folded into det_next_s
                    // first, so it wins over the timeout.
                    if (&det_next_s) begin
                        adc_run <= 1'b0;
                        state_r <= ST_ACC;
                    end else if (cnt_r == CNT_W'(TIMEOUT)) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (!det_next_s[i]) begin
                                lat_r[i] <= CNT_ZERO;
                            end
                        end
                        tmo_flags <= tmo_flags | ~det_next_s;
                        adc_run   <= 1'b0;
                        state_r   <= ST_ACC;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end

                ST_ACC: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        // A timeout anywhere in the run pins the channel.
                        if (tmo_flags[i]) begin
                            result[i*CNT_W +: CNT_W] <= CNT_ONES;
                        end else begin
                            result[i*CNT_W +: CNT_W] <= sat_add(result[i*CNT_W +: CNT_W], lat_r[i]);
                        end
`ifdef DEL_MEAS_MINMAX_EN
                        // Only trials where this channel actually detected count.
                        if (det_r[i]) begin
                            if (lat_r[i] < lat_min[i*CNT_W +: CNT_W]) begin
                                lat_min[i*CNT_W +: CNT_W] <= lat_r[i];
                            end
                            if (lat_r[i] > lat_max[i*CNT_W +: CNT_W]) begin
                                lat_max[i*CNT_W +: CNT_W] <= lat_r[i];
                            end
                        end
`endif
                    end
                    if (trial_r == num_reps) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        dac_out   <= DAC_ZERO;
                        dac_valid <= {NUM_DAC{1'b0}};
                        adc_run   <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        trial_r  <= trial_r + REP_W'(1'b1);
                        settle_r <= {SET_W{1'b0}};
                        state_r  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (settle_r == SET_W'(SETTLE_CYCLES - 1)) begin
                        dac_out <= fire_data_s;
                        adc_run <= 1'b1;
                        state_r <= ST_FIRE;
                    end else begin
                        settle_r <= settle_r + SET_W'(1'b1);
                    end
                end

                ST_DONE: begin
                    // Waiting for start to drop prevents a held start from
                    // retriggering; results and done stay put.
                    if (!start) begin
                        state_r <= ST_IDLE;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    dac_out   <= DAC_ZERO;
                    dac_valid <= {NUM_DAC{1'b0}};
                    adc_run   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_del_meas_engine.sv
module tb_del_meas_engine;

    localparam int NB  = 16;
    localparam int ND  = 3;
    localparam int NC  = 2;
    localparam int CW  = 16;
    localparam int TMO = 255;
    localparam int RW  = 4;
    localparam int SC  = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ND-1:0]      dac_sel;
    logic [NB-1:0]      pulse_val;
    logic [NB-1:0]      thresh;
    logic [RW-1:0]      num_reps;
    logic [ND*NB-1:0]   dac_out;
    logic [ND-1:0]      dac_valid;
    logic [NC*NB-1:0]   adc_in;
    logic [NC-1:0]      adc_valid;
    logic               adc_run;
    logic [NC*CW-1:0]   result;
    logic [NC-1:0]      tmo_flags;
    logic               busy;
    logic               done;
`ifdef DEL_MEAS_MINMAX_EN
    logic [NC*CW-1:0]   lat_min;
    logic [NC*CW-1:0]   lat_max;
`endif

    del_meas_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dac_sel   (dac_sel),
        .pulse_val (pulse_val),
        .thresh    (thresh),
        .num_reps  (num_reps),
        .dac_out   (dac_out),
        .dac_valid (dac_valid),
        .adc_in    (adc_in),
        .adc_valid (adc_valid),
        .adc_run   (adc_run),
        .result    (result),
        .tmo_flags (tmo_flags),
        .busy      (busy),
`ifdef DEL_MEAS_MINMAX_EN
        .lat_min   (lat_min),
        .lat_max   (lat_max),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Echo schedule: dly[trial][ch] = cycles after FIRE where the crossing
    // sample appears; 0 means the channel never crosses in that trial.
    int dly [16][NC];
    bit neg_min_echo;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample whose magnitude is at most th (often exactly th).
    function automatic logic [NB-1:0] noise_smp(input logic [NB-1:0] th);
        logic [31:0] m;
        logic [31:0] n;
        if ($urandom_range(2, 0) == 0) m = {16'h0000, th};
        else                           m = $urandom_range({16'h0000, th}, 32'd0);
        n = 32'd0 - m;
        if ($urandom_range(1, 0) == 1) return n[NB-1:0];
        else                           return m[NB-1:0];
    endfunction

    // Sample whose magnitude is strictly above th.
    function automatic logic [NB-1:0] cross_smp(input logic [NB-1:0] th);
        logic [31:0] m;
        logic [31:0] n;
        if (neg_min_echo) return 16'h8000;
        m = $urandom_range(32'd32767, {16'h0000, th} + 32'd1);
        n = 32'd0 - m;
        if ($urandom_range(1, 0) == 1) return n[NB-1:0];
        else                           return m[NB-1:0];
    endfunction

    task automatic run(input string tag, input int reps, input logic [ND-1:0] sel,
                       input logic [NB-1:0] pv, input logic [NB-1:0] th);
        logic [CW-1:0]    e_res [NC];
        logic [CW-1:0]    e_min [NC];
        logic [CW-1:0]    e_max [NC];
        logic [NC-1:0]    e_tmo;
        logic [ND*NB-1:0] e_fire;
        logic [NC*NB-1:0] av;
        logic [NC-1:0]    vv;
        logic [CW-1:0]    lv;
        int               meas [16];
        int               mx, d, k, seen, last_fire, sum;
        bit               any_to, prev_run, fin;

        // Reference model: per-trial latency from the echo schedule.
        e_tmo = '0;
        for (int c = 0; c < NC; c++) begin
            e_res[c] = 16'h0000; e_min[c] = 16'hFFFF; e_max[c] = 16'h0000;
        end
        for (int t = 0; t <= reps; t++) begin
            mx = 0; any_to = 1'b0;
            for (int c = 0; c < NC; c++) begin
                d = dly[t][c];
                if (d >= 1 && d <= TMO) begin
                    lv = d[CW-1:0];
                    if (d > mx) mx = d;
                    if (lv < e_min[c]) e_min[c] = lv;
                    if (lv > e_max[c]) e_max[c] = lv;
                end else begin
                    d = 0; e_tmo[c] = 1'b1; any_to = 1'b1;
                end
                if (e_tmo[c]) e_res[c] = 16'hFFFF;
                else begin
                    sum = int'(e_res[c]) + d;
                    e_res[c] = (sum > 65535) ? 16'hFFFF : sum[CW-1:0];
                end
            end
            meas[t] = any_to ? TMO : mx;
        end
        for (int j = 0; j < ND; j++) e_fire[j*NB +: NB] = sel[j] ? pv : 16'h0000;

        dac_sel = sel; pulse_val = pv; thresh = th; num_reps = reps[RW-1:0];
        start = 1'b1;
        prev_run = adc_run; k = 0; seen = 0; last_fire = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (adc_run && !prev_run) begin
                check_val({tag, " fire_dac"}, 64'(dac_out), 64'(e_fire));
                if (seen == 0) check_val({tag, " busy"}, 64'(busy), 64'd1);
                else check_val({tag, " fire_gap"}, 64'(cyc - last_fire), 64'(2 + meas[seen-1] + SC));
                last_fire = cyc; k = 0; seen++;
            end else begin
                k++;
            end
            prev_run = adc_run;
            if (seen == 1 && k == 1) begin
                check_val({tag, " meas_dac"}, 64'(dac_out), 64'd0);
                check_val({tag, " meas_valid"}, 64'(dac_valid), 64'(3'b111));
            end
            if (done) begin
                fin = 1'b1;
            end else begin
                for (int c = 0; c < NC; c++) begin
                    d = (seen > 0 && seen <= 16) ? dly[seen-1][c] : 0;
                    if (adc_run && seen > 0 && d > 0 && k == d) begin
                        av[c*NB +: NB] = cross_smp(th); vv[c] = 1'b1;
                    end else if (d == 0 || k < d || !adc_run) begin
                        if ($urandom_range(7, 0) == 0) begin
                            av[c*NB +: NB] = cross_smp(th); vv[c] = 1'b0;
                        end else begin
                            av[c*NB +: NB] = noise_smp(th); vv[c] = 1'($urandom_range(1, 0));
                        end
                    end else begin
                        lv = 16'($urandom);
                        av[c*NB +: NB] = lv; vv[c] = 1'($urandom_range(1, 0));
                    end
                end
                adc_in = av; adc_valid = vv;
            end
        end
        if (!fin) check_val({tag, " done_wait"}, 64'd0, 64'd1);
        check_val({tag, " trials"}, 64'(seen), 64'(reps + 1));
        for (int c = 0; c < NC; c++) begin
            check_val({tag, " result"}, 64'(result[c*CW +: CW]), 64'(e_res[c]));
`ifdef DEL_MEAS_MINMAX_EN
            check_val({tag, " lat_min"}, 64'(lat_min[c*CW +: CW]), 64'(e_min[c]));
            check_val({tag, " lat_max"}, 64'(lat_max[c*CW +: CW]), 64'(e_max[c]));
`endif
        end
        check_val({tag, " tmo"}, 64'(tmo_flags), 64'(e_tmo));
        check_val({tag, " busy_end"}, 64'(busy), 64'd0);
        check_val({tag, " valid_end"}, 64'(dac_valid), 64'd0);
        // Held start must not retrigger.
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, " no_retrig"}, 64'({done, busy, adc_run}), 64'(3'b100));
        start = 1'b0;
        @(posedge clk); #1;
        check_val({tag, " done_hold"}, 64'(done), 64'd1);
        check_val({tag, " res_hold"}, 64'(result), 64'({e_res[1], e_res[0]}));
    endtask

    initial begin
        int r;
        rst = 1'b1; start = 1'b0; dac_sel = '0; pulse_val = '0; thresh = '0;
        num_reps = '0; adc_in = '0; adc_valid = '0; neg_min_echo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out", 64'({dac_out, dac_valid, adc_run, tmo_flags, busy, done}), 64'd0);
        check_val("reset_res", 64'(result), 64'd0);
        rst = 1'b0;

        dly[0][0] = 5; dly[0][1] = 5;
        run("both5", 0, 3'b111, 16'd1000, 16'd100);

        for (int t = 0; t < 4; t++) begin dly[t][0] = 3; dly[t][1] = 9; end
        run("reps4", 3, 3'b101, 16'd1000, 16'd100);

        dly[0][0] = 7; dly[0][1] = 0;
        run("nl_lost", 0, 3'b001, 16'd1000, 16'd100);

        dly[0][0] = 4; dly[0][1] = 0; dly[1][0] = 6; dly[1][1] = 2;
        run("sticky", 1, 3'b011, 16'd500, 16'd200);

        neg_min_echo = 1'b1;
        dly[0][0] = 6; dly[0][1] = 4;
        run("negmin", 0, 3'b010, 16'h7FFF, 16'd32766);
        neg_min_echo = 1'b0;

        // Abort mid-measurement with reset.
        adc_valid = '0; dac_sel = 3'b111; num_reps = 4'd2; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check_val("abort_out", 64'({dac_out, dac_valid, adc_run, tmo_flags, busy, done}), 64'd0);
        check_val("abort_res", 64'(result), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        dly[0][0] = 0; dly[0][1] = 0;
        run("nosel", 0, 3'b000, 16'd1000, 16'd100);

        dly[0][0] = TMO; dly[0][1] = 1;
        run("edge_tmo", 0, 3'b100, 16'd1234, 16'd50);

        dly[0][0] = 4; dly[0][1] = 4; dly[1][0] = 7; dly[1][1] = 7; dly[2][0] = 5; dly[2][1] = 5;
        run("minmax", 2, 3'b111, 16'd1000, 16'd100);

        for (int n = 0; n < 6; n++) begin
            int reps;
            reps = $urandom_range(3, 0);
            for (int t = 0; t <= reps; t++) begin
                for (int c = 0; c < NC; c++) begin
                    r = $urandom_range(9, 0);
                    if (r == 0)      dly[t][c] = 0;
                    else if (r == 1) dly[t][c] = TMO;
                    else             dly[t][c] = $urandom_range(40, 1);
                end
            end
            run("rand", reps, 3'($urandom), 16'($urandom), 16'($urandom_range(30000, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
